// File: rtl/mcctrl_pkg.sv
// mcctrl_pkg: shared types and encodings for the multicycle controller.
// States, instruction classes, sub-ops and datapath mux encodings.
package mcctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_I_EXEC   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ALU_WB   = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [1:0] CLS_JUMP = 2'b00;
  localparam logic [1:0] CLS_R    = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_IM   = 2'b11;

  localparam logic [3:0] SUB_LI  = 4'b1001;
  localparam logic [3:0] SUB_LUI = 4'b1010;
  localparam logic [3:0] SUB_LWI = 4'b1011;
  localparam logic [3:0] SUB_SWI = 4'b1100;
  localparam logic [3:0] SUB_LW  = 4'b1101;
  localparam logic [3:0] SUB_SW  = 4'b1110;

  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_SIMM = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    MK_NONE,
    MK_ALU,
    MK_LOAD,
    MK_STORE
  } memkind_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/mcctrl_outdec.sv
// mcctrl_outdec: Moore output decoder for the multicycle controller.
// Pure combinational map from registered state and opcode to strobes.
module mcctrl_outdec
  import mcctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  state_e           state_i,
  input  logic [OPC_W-1:0] opc_i,
  input  logic             rdy_i,
  output ctrl_t            ctrl_o,
  output logic [OPC_W-3:0] aluop_o
);

  logic [1:0]       cls;
  logic [OPC_W-3:0] sub;

  assign cls = opc_i[OPC_W-1 -: 2];
  assign sub = opc_i[OPC_W-3:0];

  // Decode every state with all outputs defaulted low first
  always_comb begin
    ctrl_o  = '0;
    aluop_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ASB_FOUR;
        ctrl_o.ir_write  = rdy_i;
        ctrl_o.pc_write  = rdy_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = ASB_SIMM;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        aluop_o          = sub;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_REG;
        aluop_o          = sub;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ASB_REG;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        aluop_o              = sub;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = (cls == CLS_R);
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: registered Moore FSM for the multicycle datapath.
// MCCTRL_MEMWAIT_EN enables the mem_ready wait-state handshake.
module multicycle_ctrl
  import mcctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               mem_ready,
  output logic [3:0]         state,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [OPC_W-3:0]   ALUOp,
  output logic               trap
);

  localparam int SUB_W = OPC_W - 2;

  state_e           state_q, state_d;
  logic             trap_q, trap_d;
  logic             rdy;
  logic [OPC_W-1:0] opc;
  logic [1:0]       cls;
  logic             mode;
  logic [SUB_W-1:0] sub;
  memkind_e         mk;
  ctrl_t            ctrl;

  logic dec_nop, dec_jump, dec_r;
  logic dec_br, dec_imm, dec_mem, dec_ill;

`ifdef MCCTRL_MEMWAIT_EN
  assign rdy = mem_ready;
  logic unused_bits;
  assign unused_bits = ^instr_in[INSTR_W-OPC_W-1:0];
`else
  // Memory always completes in one cycle in this build
  assign rdy = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{instr_in[INSTR_W-OPC_W-1:0], mem_ready};
`endif

  assign opc  = instr_in[INSTR_W-1 -: OPC_W];
  assign cls  = opc[OPC_W-1 -: 2];
  assign mode = opc[OPC_W-3];
  assign sub  = opc[OPC_W-3:0];

  // Classify the immediate/memory sub-op
  always_comb begin
    mk = MK_NONE;
    case (sub)
      SUB_W'(SUB_LI),  SUB_W'(SUB_LUI): mk = MK_ALU;
      SUB_W'(SUB_LWI), SUB_W'(SUB_LW):  mk = MK_LOAD;
      SUB_W'(SUB_SWI), SUB_W'(SUB_SW):  mk = MK_STORE;
      default:                          mk = MK_NONE;
    endcase
  end

  assign dec_nop  = (opc == '0);
  assign dec_jump = (cls == CLS_JUMP) && !dec_nop;
  assign dec_r    = (cls == CLS_R);
  assign dec_br   = (cls == CLS_BR);
  assign dec_imm  = (cls == CLS_IM) && !mode;
  assign dec_mem  = (cls == CLS_IM) && mode
                 && (mk != MK_NONE);
  assign dec_ill  = (cls == CLS_IM) && mode
                 && (mk == MK_NONE);

  // Next-state logic; stalls hold in place
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          dec_nop:  state_d = S_FETCH;
          dec_jump: state_d = S_JUMP;
          dec_r:    state_d = S_R_EXEC;
          dec_br:   state_d = S_BRANCH;
          dec_imm:  state_d = S_I_EXEC;
          dec_mem:  state_d = S_MEM_ADDR;
          dec_ill:  state_d = S_TRAP;
          default:  state_d = S_IDLE;
        endcase
      end
      S_MEM_ADDR: begin
        unique case (mk)
          MK_LOAD:  state_d = S_MEM_RD;
          MK_STORE: state_d = S_MEM_WR;
          MK_ALU:   state_d = S_ALU_WB;
          default:  state_d = S_TRAP;
        endcase
      end
      S_R_EXEC, S_I_EXEC: state_d = S_ALU_WB;
      S_BRANCH, S_JUMP,
      S_ALU_WB, S_MEM_WB: state_d = S_FETCH;
      S_MEM_RD: if (rdy) state_d = S_MEM_WB;
      S_MEM_WR: if (rdy) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  assign trap_d = trap_q || (state_d == S_TRAP);

  // State and sticky trap registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  mcctrl_outdec #(
    .OPC_W (OPC_W)
  ) u_outdec (
    .state_i (state_q),
    .opc_i   (opc),
    .rdy_i   (rdy),
    .ctrl_o  (ctrl),
    .aluop_o (ALUOp)
  );

  assign state       = state_q;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign trap        = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Directed per-cycle state sequences; monitor compares at negedge.
module tb_multicycle_ctrl;
  import mcctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  state;
  logic        PCWrite, PCWriteCond, IorD;
  logic        MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite;
  logic        RegDst, trap;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_in    (instr_in),
    .mem_ready   (mem_ready),
    .state       (state),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    state_e      st;
    logic [18:0] o;
    string       tag;
  } exp_t;

  exp_t        q[$];
  exp_t        e_m;
  int          total = 0;
  int          bad = 0;
  event        sample_ev;
  logic [5:0]  opc_cur = '0;
  logic [18:0] act;

  assign act = {PCWrite, PCWriteCond, IorD,
                MemRead, MemWrite, IRWrite,
                MemtoReg, ALUSrcA, RegWrite,
                RegDst, PCSource, ALUSrcB,
                ALUOp, trap};

  function automatic logic [18:0] exp_out(
    input state_e     s,
    input logic [5:0] opc,
    input logic       rdy
  );
    logic pcw, pcwc, iord, mrd, mwr, irw;
    logic m2r, asa, rw, rdst, trp;
    logic [1:0] pcs, asb;
    logic [3:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw} = '0;
    {m2r, asa, rw, rdst, trp} = '0;
    pcs = 2'b00;
    asb = 2'b00;
    aop = 4'b0000;
    case (s)
      S_FETCH: begin
        mrd = 1'b1; asb = 2'b01;
        irw = rdy;  pcw = rdy;
      end
      S_DECODE: asb = 2'b11;
      S_MEM_ADDR, S_I_EXEC: begin
        asa = 1'b1; asb = 2'b10; aop = opc[3:0];
      end
      S_R_EXEC: begin
        asa = 1'b1; aop = opc[3:0];
      end
      S_BRANCH: begin
        asa = 1'b1; aop = opc[3:0];
        pcwc = 1'b1; pcs = 2'b01;
      end
      S_JUMP: begin
        pcw = 1'b1; pcs = 2'b10;
      end
      S_MEM_RD: begin
        mrd = 1'b1; iord = 1'b1;
      end
      S_MEM_WR: begin
        mwr = 1'b1; iord = 1'b1;
      end
      S_ALU_WB: begin
        rw = 1'b1; rdst = (opc[5:4] == 2'b01);
      end
      S_MEM_WB: begin
        rw = 1'b1; m2r = 1'b1;
      end
      S_TRAP: trp = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw,
            m2r, asa, rw, rdst, pcs, asb,
            aop, trp};
  endfunction

  function automatic logic eff_rdy(input logic r);
`ifdef MCCTRL_MEMWAIT_EN
    return r;
`else
    return 1'b1 | r;
`endif
  endfunction

  task automatic push(
    input state_e s,
    input logic   r,
    input string  tag
  );
    exp_t e;
    e.st  = s;
    e.o   = exp_out(s, opc_cur, eff_rdy(r));
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step(
    input state_e s,
    input logic   r,
    input string  tag
  );
    mem_ready = r;
    push(s, r, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [5:0] o);
    opc_cur  = o;
    instr_in = {o, 26'h2AAAAAA};
  endtask

  task automatic alu_seq(
    input logic [5:0] o,
    input state_e     ex,
    input string      tag
  );
    set_op(o);
    step(S_FETCH, 1'b1, tag);
    step(S_DECODE, 1'b1, tag);
    step(ex, 1'b1, tag);
    step(S_ALU_WB, 1'b1, tag);
  endtask

  // Monitor: pop one expectation per sample point
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
        e_m = q.pop_front();
        total++;
        if (state !== e_m.st || act !== e_m.o) begin
          bad++;
          $display("FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
                   e_m.tag, state, act, e_m.st, e_m.o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    step(S_IDLE, 1'b1, "reset");
    step(S_IDLE, 1'b1, "reset");
    reset_n = 1'b1;
    step(S_IDLE, 1'b1, "release");

    set_op(6'b00_0000);
    repeat (3) begin
      step(S_FETCH, 1'b1, "nop");
      step(S_DECODE, 1'b1, "nop");
    end

    alu_seq(6'b01_0010, S_R_EXEC, "rtype");
    alu_seq(6'b11_0101, S_I_EXEC, "itype");
    alu_seq(6'b11_1001, S_MEM_ADDR, "li");
    alu_seq(6'b11_1010, S_MEM_ADDR, "lui");

    set_op(6'b00_0011);
    step(S_FETCH, 1'b1, "jump");
    step(S_DECODE, 1'b1, "jump");
    step(S_JUMP, 1'b1, "jump");

    set_op(6'b10_0001);
    step(S_FETCH, 1'b1, "branch");
    step(S_DECODE, 1'b1, "branch");
    step(S_BRANCH, 1'b1, "branch");

    set_op(6'b11_1110);
`ifdef MCCTRL_MEMWAIT_EN
    step(S_FETCH, 1'b0, "sw_wait");
    step(S_FETCH, 1'b1, "sw_wait");
    step(S_DECODE, 1'b1, "sw_wait");
    step(S_MEM_ADDR, 1'b1, "sw_wait");
    step(S_MEM_WR, 1'b0, "sw_wait");
    step(S_MEM_WR, 1'b1, "sw_wait");
`else
    step(S_FETCH, 1'b0, "sw_nowait");
    step(S_DECODE, 1'b0, "sw_nowait");
    step(S_MEM_ADDR, 1'b0, "sw_nowait");
    step(S_MEM_WR, 1'b0, "sw_nowait");
`endif

    set_op(6'b11_1101);
`ifdef MCCTRL_MEMWAIT_EN
    step(S_FETCH, 1'b1, "lw_wait");
    step(S_DECODE, 1'b1, "lw_wait");
    step(S_MEM_ADDR, 1'b1, "lw_wait");
    step(S_MEM_RD, 1'b0, "lw_wait");
    step(S_MEM_RD, 1'b0, "lw_wait");
    step(S_MEM_RD, 1'b1, "lw_wait");
    step(S_MEM_WB, 1'b1, "lw_wait");
`else
    step(S_FETCH, 1'b0, "lw_nowait");
    step(S_DECODE, 1'b0, "lw_nowait");
    step(S_MEM_ADDR, 1'b0, "lw_nowait");
    step(S_MEM_RD, 1'b0, "lw_nowait");
    step(S_MEM_WB, 1'b0, "lw_nowait");
`endif

    set_op(6'b11_1100);
    step(S_FETCH, 1'b1, "swi");
    step(S_DECODE, 1'b1, "swi");
    step(S_MEM_ADDR, 1'b1, "swi");
    mem_ready = 1'b0;
    push(S_MEM_WR, 1'b0, "swi_wr");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    push(S_IDLE, 1'b0, "rst_in_wr");
    #1;
    ->sample_ev;
    @(posedge clk);
    #1;
    step(S_IDLE, 1'b0, "rst_hold");
    reset_n = 1'b1;
    set_op(6'b11_1111);
    step(S_IDLE, 1'b1, "rst_rel");

    step(S_FETCH, 1'b1, "illegal");
    step(S_DECODE, 1'b1, "illegal");
    for (int i = 0; i < 20; i++)
      step(S_TRAP, i[0], "trap_hold");

    reset_n = 1'b0;
    step(S_IDLE, 1'b1, "trap_clr");
    reset_n = 1'b1;
    set_op(6'b00_0000);
    step(S_IDLE, 1'b1, "trap_rel");
    step(S_FETCH, 1'b1, "post_trap");
    step(S_DECODE, 1'b1, "post_trap");
    step(S_FETCH, 1'b1, "post_trap");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, expected 0",
               q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit: a registered Moore FSM that sequences fetch, decode, execute, memory and write-back for the 2-bit-class instruction set. It sits between the instruction register (`instr_in`) and the datapath muxes, register file, PC and memory. Compared with the earlier controller it adds:
- parametrised opcode and instruction width;
- a memory ready handshake with wait states;
- a reset idle state;
- a sticky trap on illegal memory sub-ops;
- fully specified outputs in every state, with fetch actually strobing MemRead, IRWrite and PCWrite.

## Interface
- `INSTR_W`, 32: instruction width; opcode is `instr_in[INSTR_W-1 -: OPC_W]`.
- `OPC_W`, 6: opcode width; class = opcode[OPC_W-1:OPC_W-2], mode bit = opcode[OPC_W-3], sub-op = opcode[OPC_W-3:0].
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `instr_in`  in  INSTR_W  IR contents, stable from DECODE until the next FETCH.
- `mem_ready`  in  1  memory completes access this cycle.
- `state`  out  4  current state (debug).
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath strobes/selects.
- `PCSource`, `ALUSrcB`  out  2 each  mux selects.
- `ALUOp`  out  OPC_W-2  ALU function; 0 = add.
- `trap`  out  1  illegal instruction seen; sticky.

## Operation
- States, with outputs (any output not listed is 0):
  - IDLE: all 0.
  - FETCH: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=`mem_ready`.
  - DECODE: ALUSrcB=11.
  - MEM_ADDR, I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=sub-op.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=sub-op.
  - BRANCH: as R_EXEC, plus PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - MEM_RD: MemRead=1, IorD=1.
  - MEM_WR: MemWrite=1, IorD=1.
  - ALU_WB: RegWrite=1, RegDst=1 iff class 01.
  - MEM_WB: RegWrite=1, MemtoReg=1.
  - TRAP: all 0, trap=1.
- Transitions:
  - IDLE goes to FETCH.
  - FETCH goes to DECODE when `mem_ready`, otherwise holds.
  - DECODE dispatches on the opcode:
    - opcode all-zero (NOP) → FETCH;
    - class 00 → JUMP;
    - class 01 → R_EXEC;
    - class 10 → BRANCH;
    - class 11 with mode=0 → I_EXEC;
    - class 11 with mode=1 → MEM_ADDR if sub-op ∈ {LI 1001, LUI 1010, LWI 1011, SWI 1100, LW 1101, SW 1110}, else TRAP.
  - MEM_ADDR: LWI/LW → MEM_RD; SWI/SW → MEM_WR; LI/LUI → ALU_WB.
  - I_EXEC and R_EXEC go to ALU_WB.
  - BRANCH, JUMP, ALU_WB and MEM_WB go to FETCH.
  - MEM_RD goes to MEM_WB when `mem_ready`, otherwise holds. MEM_WR goes to FETCH when `mem_ready`, otherwise holds.
  - TRAP holds until reset.
- Sub-op constants are defined at 4 bits and zero-extended to OPC_W-2.
- Outputs are decoded combinationally from the registered state and `instr_in` only. `mem_ready` affects only the FETCH strobes and state holds.
- Unused state encodings go to IDLE on the next edge.

## Timing
- `reset_n` low: state = IDLE asynchronously, so every output is 0 and `trap`=0 immediately. The first FETCH is the cycle after release.
- Reset mid-instruction aborts it with no further strobes. A partial write-back never completes.
- Zero-wait cycle counts, FETCH to the next FETCH:
  - NOP 2;
  - jump 3;
  - branch 3;
  - R-type, I-type, LI/LUI 4;
  - SW/SWI 4;
  - LW/LWI 5.
- Each cycle that `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- PCWrite and IRWrite pulse in FETCH only on the `mem_ready` cycle, exactly once per instruction.
- Memory strobes stay asserted for the whole wait.

## Configuration
- `MCCTRL_MEMWAIT_EN` defined: `mem_ready` handshake as above.
- `MCCTRL_MEMWAIT_EN` undefined: `mem_ready` is ignored and treated as 1. FETCH, MEM_RD and MEM_WR last exactly one cycle, and IRWrite/PCWrite are 1 throughout FETCH.

## Structure
- Package `mcctrl_pkg` holds:
  - the state enum (4-bit);
  - class codes;
  - sub-op constants;
  - ALUSrcB encodings: 00 reg, 01 const 4, 10 imm, 11 shifted imm;
  - PCSource encodings: 00 ALU, 01 ALUOut, 10 jump target.
- One sub-module, `mcctrl_outdec`: purely combinational state/instr → control-output decoder. The top module holds the state register, next-state logic and the trap flag.

## Test plan
- Reset release, `instr_in`=0 (NOP), `mem_ready`=1 → IDLE, FETCH, DECODE, FETCH…, with IRWrite high one cycle in every two.
- R-type opcode 01_0010, `mem_ready`=1 → FETCH, DECODE, R_EXEC (ALUOp=0010, ALUSrcB=00), ALU_WB (RegWrite=1, RegDst=1), FETCH: 4 cycles.
- LW opcode 11_1101 with `mem_ready` low 2 cycles in MEM_RD → MEM_RD held 3 cycles with MemRead=IorD=1, then MEM_WB with MemtoReg=1: 7 cycles total.
- Illegal opcode 11_1111 → TRAP, `trap`=1, all strobes 0 for 20 cycles; `reset_n` pulse clears `trap`.
- `reset_n` asserted during MEM_WR → MemWrite drops in the same cycle and state=IDLE. With `MCCTRL_MEMWAIT_EN` undefined and `mem_ready`=0, a SW completes in 4 cycles.
